lut_self_checker: RTL and testbench

//   Parametrised, registered truth-table function unit with built-in self-check.

---
 rtl/lut_self_checker.sv | 120 ++++++++++++
 tb/tb_lut_self_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lut_self_checker.sv
// Registered N_IN-input truth-table unit with a programmable LUT, per-sample golden check,
// and a sweep mode that walks every input code and counts mismatches against REF_TABLE.
module lut_self_checker #(
    parameter int                    N_IN        = 3,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = 8'b00111001,
    parameter logic [(1<<N_IN)-1:0] REF_TABLE   = 8'b00111001,
    parameter int                    CW          = N_IN + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      x,
    output logic                 z,
    output logic                 z_valid,
    output logic                 error,
    input  logic                 cfg_we,
    input  logic [(1<<N_IN)-1:0] cfg_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        err_count
);

    // state | meaning
    // IDLE  | accepts cfg writes, single evaluations and start
    // SWEEP | compares lut[idx] to REF_TABLE[idx], one code per edge
    // DONE  | err_count final, done strobe, returns to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int              DEPTH    = 1 << N_IN;
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(DEPTH - 1);

    state_t              state;
    state_t              state_nxt;
    logic [N_IN-1:0]     idx;
    logic [DEPTH-1:0]    lut;
    logic                eval_z;
    logic                eval_miss;
    logic                sweep_miss;

    assign eval_z     = lut[x];
    assign eval_miss  = lut[x] ^ REF_TABLE[x];
    assign sweep_miss = lut[idx] ^ REF_TABLE[idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                busy = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Evaluation reads lut before a same-edge cfg write lands, so z sees the old contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lut       <= TRUTH_TABLE;
            z         <= 1'b0;
            z_valid   <= 1'b0;
            error     <= 1'b0;
            idx       <= '0;
            err_count <= '0;
        end else begin
            z_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        lut <= cfg_data;
                    end
                    if (in_valid) begin
                        z       <= eval_z;
                        error   <= eval_miss;
                        z_valid <= 1'b1;
                    end
                    if (start) begin
                        idx       <= '0;
                        err_count <= '0;
                    end
                end
                SWEEP: begin
                    err_count <= err_count + CW'(sweep_miss);
                    idx       <= idx + N_IN'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_self_checker.sv
// Bench for lut_self_checker: directed and random evaluations and sweeps against a
// bit-vector model of the LUT, plus a 4-input instance for the wider-table case.
module tb_lut_self_checker;

    localparam logic [7:0]  REF8  = 8'b00111001;
    localparam logic [15:0] REF16 = 16'hA5C3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, cfg_we, start;
    logic [2:0]  x;
    logic [7:0]  cfg_data;
    logic        z, z_valid, error, busy, done;
    logic [3:0]  err_count;

    logic        in_valid4, cfg_we4, start4;
    logic [3:0]  x4;
    logic [15:0] cfg_data4;
    logic        z4, z_valid4, error4, busy4, done4;
    logic [4:0]  err_count4;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  m_lut;

    always #5 clock = ~clock;

    lut_self_checker dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .x(x), .z(z),
        .z_valid(z_valid), .error(error), .cfg_we(cfg_we), .cfg_data(cfg_data),
        .start(start), .busy(busy), .done(done), .err_count(err_count)
    );

    lut_self_checker #(.N_IN(4), .TRUTH_TABLE(REF16), .REF_TABLE(REF16)) dut4 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid4), .x(x4), .z(z4),
        .z_valid(z_valid4), .error(error4), .cfg_we(cfg_we4), .cfg_data(cfg_data4),
        .start(start4), .busy(busy4), .done(done4), .err_count(err_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One evaluation, optionally with a same-edge config write.
    task automatic eval(input logic [2:0] xv, input bit we, input logic [7:0] d);
        logic exp_z, exp_e;
        in_valid = 1'b1; x = xv; cfg_we = we; cfg_data = d;
        exp_z = m_lut[xv];
        exp_e = m_lut[xv] ^ REF8[xv];
        tick();
        in_valid = 1'b0; cfg_we = 1'b0;
        if (we) m_lut = d;
        chk("eval_zv", z_valid, 1'b1);
        chk("eval_z", z, exp_z);
        chk("eval_err", error, exp_e);
    endtask

    // Full sweep; optional eval/config on the start edge, optional ignored pokes at idx==poke_at.
    task automatic run_sweep(input int eval_x, input bit do_cfg, input logic [7:0] cfg_val,
                             input int poke_at);
        int   n, busy_n;
        bit   seen;
        logic exp_z;
        logic [3:0] ec_final;
        start = 1'b1;
        if (do_cfg) begin cfg_we = 1'b1; cfg_data = cfg_val; end
        if (eval_x >= 0) begin in_valid = 1'b1; x = 3'(eval_x); end
        exp_z = m_lut[3'(eval_x)];
        tick();
        start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
        if (do_cfg) m_lut = cfg_val;
        if (eval_x >= 0) begin
            chk("sw_eval_zv", z_valid, 1'b1);
            chk("sw_eval_z", z, exp_z);
        end
        chk("sw_busy_start", busy, 1'b1);
        chk("sw_ec_clear", err_count, 4'd0);
        busy_n = busy ? 1 : 0;
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (n == poke_at) begin
                start = 1'b1; cfg_we = 1'b1; cfg_data = ~m_lut; in_valid = 1'b1; x = 3'(i);
            end
            tick();
            n++;
            if (n == poke_at + 1) begin
                chk("sw_busy_eval_ignored", z_valid, 1'b0);
                start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
            end
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        chk("sw_done_seen", seen, 1'b1);
        chk("sw_done_edges", n, 8);
        chk("sw_err_count", err_count, $countones(m_lut ^ REF8));
        ec_final = err_count;
        tick();
        if (busy) busy_n++;
        chk("sw_done_one_cycle", done, 1'b0);
        chk("sw_busy_cycles", busy_n, 9);
        chk("sw_ec_hold", err_count, ec_final);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dp;
        logic hold_z;
        reset_n = 1'b0;
        in_valid = 0; cfg_we = 0; start = 0; x = '0; cfg_data = '0;
        in_valid4 = 0; cfg_we4 = 0; start4 = 0; x4 = '0; cfg_data4 = '0;
        m_lut = REF8;
        #3;
        chk("rst_z", z, 1'b0);
        chk("rst_zv", z_valid, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ec", err_count, 4'd0);
        chk("rst_ec4", err_count4, 5'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Default table, all codes: expect 1,0,0,1,1,1,0,0 and no errors.
        for (int i = 0; i < 8; i++) eval(3'(i), 1'b0, 8'h00);
        hold_z = z;
        tick();
        chk("idle_zv_low", z_valid, 1'b0);
        chk("idle_z_hold", z, hold_z);

        // Read-during-write uses the old table, next eval sees the new one.
        eval(3'd0, 1'b1, 8'b00111000);
        chk("rdw_old_z", z, 1'b1);
        eval(3'd0, 1'b0, 8'h00);
        chk("new_z", z, 1'b0);
        chk("new_err", error, 1'b1);
        run_sweep(-1, 1'b0, 8'h00, -1);
        chk("sweep_one_err", err_count, 4'd1);

        eval(3'd5, 1'b1, 8'b11000110);
        run_sweep(-1, 1'b0, 8'h00, -1);
        chk("sweep_all_err", err_count, 4'd8);

        // Start/cfg/eval at idx 3 ignored; lut must remain intact afterwards.
        eval(3'd1, 1'b1, 8'b00111000);
        run_sweep(-1, 1'b0, 8'h00, 3);
        chk("busy_poke_ec", err_count, 4'd1);
        eval(3'd0, 1'b0, 8'h00);
        chk("busy_poke_lut", z, 1'b0);

        // start with cfg_we and in_valid on the same edge.
        run_sweep(6, 1'b1, 8'b10111101, -1);
        chk("start_cfg_new_lut", err_count, 4'd2);

        for (int r = 0; r < 12; r++) begin
            eval(3'($urandom_range(0, 7)), 1'b1, 8'($urandom));
            for (int k = 0; k < 3; k++) eval(3'($urandom_range(0, 7)), 1'b0, 8'h00);
            run_sweep($urandom_range(0, 1) ? int'($urandom_range(0, 7)) : -1,
                      1'($urandom_range(0, 1)), 8'($urandom), -1);
        end

        // Reset at idx 5 of a sweep with mismatches present.
        eval(3'd0, 1'b1, 8'b11000110);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ec", err_count, 4'd0);
        chk("mid_rst_zv", z_valid, 1'b0);
        dp = 0;
        repeat (3) begin tick(); if (done) dp++; end
        reset_n = 1'b1;
        m_lut = REF8;
        repeat (3) begin tick(); if (done) dp++; end
        chk("mid_rst_no_done", dp, 0);
        for (int i = 0; i < 8; i++) eval(3'(i), 1'b0, 8'h00);

        // 4-input instance: flip bit 15 and sweep.
        cfg_we4 = 1'b1; cfg_data4 = REF16 ^ 16'h8000;
        tick();
        cfg_we4 = 1'b0;
        in_valid4 = 1'b1; x4 = 4'd15;
        tick();
        in_valid4 = 1'b0;
        chk("n4_z", z4, 1'b0);
        chk("n4_err", error4, 1'b1);
        start4 = 1'b1; tick(); start4 = 1'b0;
        dp = 0;
        for (int i = 0; i < 60 && !done4; i++) begin tick(); dp++; end
        chk("n4_done_edges", dp, 16);
        chk("n4_err_count", err_count4, 5'd1);
        tick();
        chk("n4_idle", busy4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
